data_bus_bridge: RTL and testbench

Multi-cycle bridge between the pipeline CPU's data-memory port (the MEM stage's `mem_addr`/`mem_byte_slct`/`mem_we`/`mem_re` outputs) and a synchronous word-wide SRAM that needs a fixed number of wait cycles. It sits directly downstream of the CPU in the SOPC, in place of the zero-latency memory model. It registers each request, drives the SRAM for a programmable number of cycles, and holds the pipeline with `stall_req` until read data is valid or the write has been issued.

---
 rtl/data_bus_bridge_pkg.sv | 27 ++
 rtl/data_bus_bridge.sv | 101 ++++++++++
 tb/tb_data_bus_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_bridge_pkg.sv
// ============================================================================
// Module   : data_bus_bridge_pkg
// Purpose  : Shared widths, FSM state encoding and counter sizing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package data_bus_bridge_pkg;

  localparam int c_reg_data_w        = 32;
  localparam int c_mem_addr_w        = 32;
  localparam int c_be_w              = 4;
  localparam int c_default_wait_cyc  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_bus_bridge.sv
// ============================================================================
// Module   : data_bus_bridge
// Purpose  : Multi-cycle bridge from the CPU data port to a wait-state SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = c_default_wait_cyc,
  parameter int SRAM_ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [c_mem_addr_w-1:0]  cpu_addr,
  input  logic [c_be_w-1:0]        cpu_byte_slct,
  input  logic [c_reg_data_w-1:0]  cpu_wdata,
  input  logic                     cpu_we,
  input  logic                     cpu_re,
  output logic [c_reg_data_w-1:0]  cpu_rdata,
  output logic                     stall_req,
  output logic                     bus_err,
  output logic                     sram_ce,
  output logic                     sram_we,
  output logic [c_be_w-1:0]        sram_be,
  output logic [SRAM_ADDR_W-1:0]   sram_addr,
  output logic [c_reg_data_w-1:0]  sram_wdata,
  input  logic [c_reg_data_w-1:0]  sram_rdata
);

  localparam int                 CNT_W      = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]   c_cnt_load = CNT_W'(WAIT_CYCLES);

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [SRAM_ADDR_W-1:0]    addr_q;
  logic [c_be_w-1:0]         be_q;
  logic [c_reg_data_w-1:0]   wdata_q;
  logic                      op_wr_q;
  logic [c_reg_data_w-1:0]   rdata_q;

  logic w_req;
  logic w_last;
  logic w_unused_addr;

  assign w_req         = cpu_re | cpu_we;
  assign w_last        = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign w_unused_addr = ^{cpu_addr[c_mem_addr_w-1:SRAM_ADDR_W+2], cpu_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            addr_q  <= cpu_addr[SRAM_ADDR_W+1:2];
            be_q    <= cpu_byte_slct;
            wdata_q <= cpu_wdata;
            op_wr_q <= cpu_we;
            cnt_q   <= c_cnt_load;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!op_wr_q) begin
              rdata_q <= sram_rdata;
            end
            state_q <= ST_DONE;
          end
        end
        // The request still visible in DONE is the one just served.
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_req  = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && w_req);
  assign bus_err    = (state_q == ST_IDLE) && cpu_re && cpu_we;
  assign sram_ce    = (state_q == ST_ACCESS);
  // Gating with rst guarantees no write strobe escapes in the reset cycle.
  assign sram_we    = w_last && op_wr_q && !rst;
  assign sram_be    = be_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign cpu_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
// ============================================================================
// Module   : tb_data_bus_bridge
// Purpose  : Scoreboard bench for data_bus_bridge at WAIT_CYCLES 2, 0 and 15.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_bus_bridge;

  localparam int WCS [3] = '{2, 0, 15};

  typedef struct {
    int          k;
    int          len;
    bit          is_wr;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          errs;
    int          gap;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic        re_v   [3];
  logic        we_v   [3];
  logic [31:0] rdata_v[3];
  logic        stall_v[3];
  logic        err_v  [3];
  logic        ce_v   [3];
  logic        swe_v  [3];
  logic [3:0]  be_v   [3];
  logic [9:0]  saddr_v[3];
  logic [31:0] swd_v  [3];
  logic [31:0] srd_v  [3];

  logic [31:0] mem [1024];

  int   n_cmp;
  int   n_err;
  exp_t sbq[$];
  exp_t mon_e;
  int   swe_total;

  bit          act_m  [3];
  bit          ab_m   [3];
  int          len_m  [3];
  int          errs_m [3];
  int          wecnt_m[3];
  int          low_m  [3];
  int          gap_m  [3];
  logic [9:0]  acc_m  [3];
  logic [9:0]  wea_m  [3];
  logic [3:0]  web_m  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_bus_bridge #(
      .WAIT_CYCLES (WCS[g]),
      .SRAM_ADDR_W (10)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_addr      (cpu_addr),
      .cpu_byte_slct (cpu_be),
      .cpu_wdata     (cpu_wdata),
      .cpu_we        (we_v[g]),
      .cpu_re        (re_v[g]),
      .cpu_rdata     (rdata_v[g]),
      .stall_req     (stall_v[g]),
      .bus_err       (err_v[g]),
      .sram_ce       (ce_v[g]),
      .sram_we       (swe_v[g]),
      .sram_be       (be_v[g]),
      .sram_addr     (saddr_v[g]),
      .sram_wdata    (swd_v[g]),
      .sram_rdata    (srd_v[g])
    );
    assign srd_v[g] = mem[saddr_v[g]];
  end

  // Only the WAIT_CYCLES=2 instance writes to the SRAM model.
  always @(posedge clk) begin
    if (ce_v[0] && swe_v[0]) begin
      for (int b = 0; b < 4; b++) begin
        if (be_v[0][b]) mem[saddr_v[0]][8*b +: 8] <= swd_v[0][8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (swe_v[0]) swe_total++;
    for (int k = 0; k < 3; k++) begin
      if (stall_v[k]) begin
        if (!act_m[k]) begin
          act_m[k]   = 1'b1;
          ab_m[k]    = 1'b0;
          len_m[k]   = 0;
          errs_m[k]  = 0;
          wecnt_m[k] = 0;
          gap_m[k]   = low_m[k];
          acc_m[k]   = '0;
          wea_m[k]   = '0;
          web_m[k]   = '0;
        end
        len_m[k]++;
        if (err_v[k]) errs_m[k]++;
        if (ce_v[k]) acc_m[k] = saddr_v[k];
        if (swe_v[k]) begin
          wecnt_m[k]++;
          wea_m[k] = saddr_v[k];
          web_m[k] = be_v[k];
        end
        if (rst) ab_m[k] = 1'b1;
        low_m[k] = 0;
      end else begin
        low_m[k]++;
        if (act_m[k]) begin
          act_m[k] = 1'b0;
          if (!ab_m[k] && !rst) begin
            if (sbq.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_done: instance %0d finished with no expected entry", k);
            end else begin
              mon_e = sbq.pop_front();
              chk("instance",    32'(k),          32'(mon_e.k));
              chk("stall_len",   32'(len_m[k]),   32'(mon_e.len));
              chk("bus_err_cnt", 32'(errs_m[k]),  32'(mon_e.errs));
              chk("sram_we_cnt", 32'(wecnt_m[k]), mon_e.is_wr ? 32'd1 : 32'd0);
              chk("access_addr", 32'(acc_m[k]),   32'(mon_e.addr));
              chk("done_ce",     32'(ce_v[k]),    32'd0);
              if (mon_e.is_wr) begin
                chk("we_addr", 32'(wea_m[k]), 32'(mon_e.addr));
                chk("we_be",   32'(web_m[k]), 32'(mon_e.be));
              end else begin
                chk("rdata", rdata_v[k], mon_e.rdata);
              end
              if (mon_e.gap >= 0) chk("gap", 32'(gap_m[k]), 32'(mon_e.gap));
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_req(input int k, input bit re, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int gap);
    exp_t e;
    bit   done;
    e.k     = k;
    e.len   = WCS[k] + 2;
    e.is_wr = we;
    e.addr  = addr[11:2];
    e.be    = be;
    e.rdata = exp_rd;
    e.errs  = (re && we) ? 1 : 0;
    e.gap   = gap;
    sbq.push_back(e);
    cpu_addr  = addr;
    cpu_be    = be;
    cpu_wdata = wd;
    re_v[k]   = re;
    we_v[k]   = we;
    done      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_v[k]) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: instance %0d stall never dropped (addr %h)", k, addr);
    end
    @(posedge clk);
    #2;
    re_v[k] = 1'b0;
    we_v[k] = 1'b0;
  endtask

  initial begin
    int sw0;
    n_cmp = 0;
    n_err = 0;
    swe_total = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2]  = 32'hAAAA_BBBB;
    mem[5]  = 32'hDEAD_BEEF;
    mem[9]  = 32'h9999_9999;
    mem[16] = 32'h1616_1616;
    for (int k = 0; k < 3; k++) begin
      re_v[k] = 1'b0;
      we_v[k] = 1'b0;
      act_m[k] = 1'b0;
      low_m[k] = 0;
    end
    cpu_addr = '0;
    cpu_be = '0;
    cpu_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("rst_rdata", rdata_v[0],        32'h0);
    chk("rst_stall", 32'(stall_v[0]),   32'h0);
    chk("rst_err",   32'(err_v[0]),     32'h0);
    chk("rst_ce",    32'(ce_v[0]),      32'h0);
    chk("rst_we",    32'(swe_v[0]),     32'h0);
    chk("rst_be",    32'(be_v[0]),      32'h0);
    chk("rst_addr",  32'(saddr_v[0]),   32'h0);
    chk("rst_wdata", swd_v[0],          32'h0);
    idle(1);

    do_req(0, 1, 0, 32'h14, 4'hF,    32'h0,         32'hDEAD_BEEF, -1);
    idle(2);
    do_req(0, 0, 1, 32'h08, 4'b0011, 32'h1234_5678, 32'h0,         -1);
    idle(1);
    do_req(0, 1, 0, 32'h08, 4'hF,    32'h0,         32'hAAAA_5678, -1);
    idle(1);
    do_req(0, 0, 1, 32'h0C, 4'hF,    32'h0BAD_C0DE, 32'h0,         -1);
    do_req(0, 1, 0, 32'h0C, 4'hF,    32'h0,         32'h0BAD_C0DE,  1);
    idle(1);
    do_req(0, 1, 1, 32'h20, 4'hF,    32'h55AA_55AA, 32'h0,         -1);
    do_req(0, 1, 0, 32'h20, 4'hF,    32'h0,         32'h55AA_55AA,  1);
    idle(1);
    do_req(0, 0, 1, 32'h24, 4'h0,    32'hFFFF_FFFF, 32'h0,         -1);
    do_req(0, 1, 0, 32'h24, 4'hF,    32'h0,         32'h9999_9999,  1);
    idle(1);
    do_req(1, 1, 0, 32'h14, 4'hF,    32'h0,         32'hDEAD_BEEF, -1);
    idle(1);
    do_req(2, 1, 0, 32'h14, 4'hF,    32'h0,         32'hDEAD_BEEF, -1);
    idle(2);

    // Write abandoned by reset in its second ACCESS cycle.
    sw0       = swe_total;
    cpu_addr  = 32'h40;
    cpu_be    = 4'hF;
    cpu_wdata = 32'hCAFE_F00D;
    we_v[0]   = 1'b1;
    idle(2);
    rst     = 1'b1;
    we_v[0] = 1'b0;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdata", rdata_v[0],      32'h0);
    chk("post_rst_stall", 32'(stall_v[0]), 32'h0);
    chk("post_rst_ce",    32'(ce_v[0]),    32'h0);
    chk("post_rst_we",    32'(swe_v[0]),   32'h0);
    chk("post_rst_be",    32'(be_v[0]),    32'h0);
    chk("post_rst_addr",  32'(saddr_v[0]), 32'h0);
    chk("post_rst_wdata", swd_v[0],        32'h0);
    chk("abort_we_cnt",   32'(swe_total - sw0), 32'h0);
    chk("abort_mem",      mem[16],         32'h1616_1616);
    idle(1);
    do_req(0, 1, 0, 32'h14, 4'hF, 32'h0, 32'hDEAD_BEEF, -1);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    idle(2);
    chk("queue_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
